fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RISC-V core. It owns the program counter, issues in-order requests to instruction memory over a valid/ready port, and buffers returned instructions in a DEPTH-entry queue. It presents them to decode with a valid/ready handshake. Redirects (taken branch, jump) flush the queue and discard stale responses, so fetch stays decoupled from execute for the pipelined core.

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit port bundle: instruction-memory request/response, redirect and decode handshake.
// The fetch unit uses the master modport; memory/decode/testbench use the slave modport.
interface fetch_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            o_imem_req_vld;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_req_rdy;
  logic            i_imem_rsp_vld;
  logic [31:0]     i_imem_rsp_data;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_instr_vld;
  logic [31:0]     o_instr;
  logic [XLEN-1:0] o_instr_pc;
  logic [XLEN-1:0] o_pc_four;
  logic            i_instr_rdy;
  logic [XLEN-1:0] o_pc_debug;
  logic [CW-1:0]   o_count;

  modport master (
    output o_imem_req_vld, o_imem_addr, o_instr_vld, o_instr, o_instr_pc, o_pc_four,
           o_pc_debug, o_count,
    input  i_imem_req_rdy, i_imem_rsp_vld, i_imem_rsp_data, i_redirect, i_redirect_pc,
           i_instr_rdy
  );

  modport slave (
    input  o_imem_req_vld, o_imem_addr, o_instr_vld, o_instr, o_instr_pc, o_pc_four,
           o_pc_debug, o_count,
    output i_imem_req_rdy, i_imem_rsp_vld, i_imem_rsp_data, i_redirect, i_redirect_pc,
           i_instr_rdy
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order memory requests under a
// credit limit, queues returned instructions for decode and flushes on redirect.
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic         i_clk,
  input logic         i_reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] ipc_q   [DEPTH];

  logic            req_vld;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic            head_vld;
  logic [SW-1:0]   credit_used;
  logic [XLEN-1:0] redirect_pc_aligned;
  logic            unused_pc_bits;

  assign unused_pc_bits      = ^bus.i_redirect_pc[1:0];
  assign redirect_pc_aligned = {bus.i_redirect_pc[XLEN-1:2], 2'b00};

  // Queued entries plus outstanding requests may never exceed the queue size.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign req_vld     = !i_reset && !bus.i_redirect && (credit_used < SW'(DEPTH));
  assign req_fire    = req_vld && bus.i_imem_req_rdy;
  assign rsp_ok      = bus.i_imem_rsp_vld && (inflight_q != '0);
  assign head_vld    = (count_q != '0);
  assign pop         = head_vld && bus.i_instr_rdy;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    push       = 1'b0;

    if (bus.i_redirect) begin
      // Every response still owed belongs to the old stream; the one arriving now is lost too.
      pc_d       = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = inflight_q - CW'(rsp_ok);
      drop_d     = inflight_q - CW'(rsp_ok);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push = 1'b1;
        end
      end
      // Responses are in order, so the next kept response's PC simply advances by 4.
      if (push) begin
        tail_d   = tail_q + PW'(1);
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q       <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (push) begin
        instr_q[tail_q] <= bus.i_imem_rsp_data;
        ipc_q[tail_q]   <= rsp_pc_q;
      end
    end
  end

  assign bus.o_imem_req_vld = req_vld;
  assign bus.o_imem_addr    = pc_q;
  assign bus.o_instr_vld    = head_vld;
  assign bus.o_instr        = head_vld ? instr_q[head_q] : '0;
  assign bus.o_instr_pc     = head_vld ? ipc_q[head_q] : '0;
  assign bus.o_pc_four      = head_vld ? ipc_q[head_q] + XLEN'(4) : '0;
  assign bus.o_pc_debug     = pc_q;
  assign bus.o_count        = count_q;

  rsp_without_request_a : assert property (
    @(posedge i_clk) disable iff (i_reset) !(bus.i_imem_rsp_vld && (inflight_q == '0))
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model, decode-side scoreboard fed by the
// directed stimulus, and direct checks of reset, credit, redirect and wrap behaviour.
module tb_fetch_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t       mq[$];
  logic [31:0] req_log[$];
  int unsigned cyc  = 0;
  int unsigned lat  = 1;
  int unsigned nreq = 0;
  logic        mem_rst;
  mreq_t       m;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: pc, instr: mem_word(pc)});
      pc = pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_redirect = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_log.delete();
    nreq = 0;
  endtask

  task automatic wait_vld(input int max_cycles);
    int n;
    n = 0;
    while (!bus.o_instr_vld && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_instr_vld) begin
      total++;
      bad++;
      $display("FAIL wait_vld: no o_instr_vld within %0d cycles", max_cycles);
    end
  endtask

  // Memory: accepts every request, answers in order `lat` cycles later.
  always @(posedge clk) begin
    cyc++;
    mem_rst = rst;
    if (rst) begin
      mq.delete();
    end else if (bus.o_imem_req_vld && bus.i_imem_req_rdy) begin
      mq.push_back('{due: cyc + lat - 1, addr: bus.o_imem_addr});
      req_log.push_back(bus.o_imem_addr);
      nreq++;
    end
    #1;
    bus.i_imem_rsp_vld  = 1'b0;
    bus.i_imem_rsp_data = '0;
    if (!mem_rst && mq.size() != 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      bus.i_imem_rsp_vld  = 1'b1;
      bus.i_imem_rsp_data = mem_word(m.addr);
    end
  end

  // Decode-side monitor: every accepted instruction must match the scoreboard head.
  exp_t        e;
  logic [31:0] four_exp;
  always @(negedge clk) begin
    if (!rst && !bus.i_redirect && bus.o_instr_vld && bus.i_instr_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc 0x%0h want no instruction", bus.o_instr_pc);
      end else begin
        e = exp_q.pop_front();
        four_exp = e.pc + 32'd4;
        check("mon_pc", bus.o_instr_pc, e.pc);
        check("mon_instr", bus.o_instr, e.instr);
        check("mon_pc_four", bus.o_pc_four, four_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_imem_req_rdy  = 1'b0;
    bus.i_imem_rsp_vld  = 1'b0;
    bus.i_imem_rsp_data = '0;
    bus.i_redirect      = 1'b0;
    bus.i_redirect_pc   = '0;
    bus.i_instr_rdy     = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_vld", bus.o_imem_req_vld, 0);
    check("rst_instr_vld", bus.o_instr_vld, 0);
    check("rst_instr", bus.o_instr, 0);
    check("rst_instr_pc", bus.o_instr_pc, 0);
    check("rst_pc_four", bus.o_pc_four, 0);
    check("rst_pc_debug", bus.o_pc_debug, RV);
    check("rst_count", bus.o_count, 0);

    // Streaming at 1-cycle latency; memory not ready during the first cycle
    do_reset();
    push_stream(32'h0, 32);
    @(negedge clk);
    check("t1_req_vld", bus.o_imem_req_vld, 1);
    check("t1_addr0", bus.o_imem_addr, 32'h0);
    step();
    bus.i_imem_req_rdy = 1'b1;
    @(negedge clk);
    check("t1_addr_held", bus.o_imem_addr, 32'h0);
    step();
    @(negedge clk);
    check("t1_vld_lat", bus.o_instr_vld, 0);
    check("t1_pc_debug", bus.o_pc_debug, 32'h4);
    step();
    @(negedge clk);
    check("t1_first_vld", bus.o_instr_vld, 1);
    check("t1_first_pc", bus.o_instr_pc, 32'h0);
    check("t1_first_four", bus.o_pc_four, 32'h4);
    step();
    @(negedge clk);
    check("t1_second_pc", bus.o_instr_pc, 32'h4);
    check("t1_count", bus.o_count, 1);
    repeat (6) step();

    // Decode stalled: credit limit, then exactly one refill per pop
    bus.i_instr_rdy = 1'b0;
    do_reset();
    push_stream(32'h0, 16);
    repeat (12) step();
    @(negedge clk);
    check("t2_nreq", nreq, 4);
    check("t2_count_full", bus.o_count, 4);
    check("t2_req_blocked", bus.o_imem_req_vld, 0);
    check("t2_head_pc", bus.o_instr_pc, 32'h0);
    step();
    bus.i_instr_rdy = 1'b1;
    step();
    bus.i_instr_rdy = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("t2_nreq_after_pop", nreq, 5);
    check("t2_count_refill", bus.o_count, 4);
    check("t2_head_after_pop", bus.o_instr_pc, 32'h4);
    check("t2_req5_addr", req_log[4], 32'h10);

    // Two pops under 3-cycle latency, then async reset with 2 queued and 2 in flight
    step();
    lat = 3;
    bus.i_instr_rdy = 1'b1;
    step();
    step();
    bus.i_instr_rdy = 1'b0;
    step();
    @(negedge clk);
    check("t6_count_pre", bus.o_count, 2);
    check("t6_req_blocked", bus.o_imem_req_vld, 0);
    check("t6_pc_debug_pre", bus.o_pc_debug, 32'h1c);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_vld", bus.o_instr_vld, 0);
    check("t6_async_count", bus.o_count, 0);
    check("t6_async_pc_debug", bus.o_pc_debug, RV);
    check("t6_async_req_vld", bus.o_imem_req_vld, 0);

    // Redirect with two stale requests in flight (latency 3)
    do_reset();
    bus.i_instr_rdy = 1'b1;
    step();
    step();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0103;
    exp_q.delete();
    push_stream(32'h100, 16);
    @(negedge clk);
    check("t3_req_during_redirect", bus.o_imem_req_vld, 0);
    step();
    bus.i_redirect = 1'b0;
    @(negedge clk);
    check("t3_vld_after", bus.o_instr_vld, 0);
    check("t3_new_req_vld", bus.o_imem_req_vld, 1);
    check("t3_new_addr", bus.o_imem_addr, 32'h100);
    step();
    @(negedge clk);
    check("t3_drop1_count", bus.o_count, 0);
    step();
    @(negedge clk);
    check("t3_drop2_count", bus.o_count, 0);
    wait_vld(10);
    check("t3_first_pc", bus.o_instr_pc, 32'h100);

    // Redirect together with a response and a pop; new stream wraps past 0xFFFF_FFFC
    lat = 1;
    do_reset();
    push_stream(32'h0, 32);
    repeat (6) step();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFF8;
    exp_q.delete();
    push_stream(32'hFFFF_FFF8, 16);
    req_log.delete();
    @(negedge clk);
    check("t4_head_vld", bus.o_instr_vld, 1);
    check("t4_count_pre", bus.o_count, 1);
    step();
    bus.i_redirect = 1'b0;
    @(negedge clk);
    check("t4_count_flushed", bus.o_count, 0);
    check("t4_vld_flushed", bus.o_instr_vld, 0);
    check("t4_new_addr", bus.o_imem_addr, 32'hFFFF_FFF8);
    step();
    @(negedge clk);
    check("t4_vld_lat", bus.o_instr_vld, 0);
    check("t4_pc_debug", bus.o_pc_debug, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("t4_first_vld", bus.o_instr_vld, 1);
    check("t4_first_pc", bus.o_instr_pc, 32'hFFFF_FFF8);
    check("t5_wrap_addr", bus.o_imem_addr, 32'h0);
    step();
    @(negedge clk);
    check("t5_top_pc", bus.o_instr_pc, 32'hFFFF_FFFC);
    check("t5_top_four", bus.o_pc_four, 32'h0);
    repeat (4) step();
    @(negedge clk);
    check("t5_req0", req_log[0], 32'hFFFF_FFF8);
    check("t5_req1", req_log[1], 32'hFFFF_FFFC);
    check("t5_req2", req_log[2], 32'h0);
    check("t5_req3", req_log[3], 32'h4);

    bus.i_instr_rdy = 1'b0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
